// File: rtl/multi_axis_input_ctrl.sv
// Multi-channel paddle/steering/spinner input controller: CLAMP ramp, WRAP spinner or ANALOG passthrough per axis.
// Optional build macro PADDLE_AUTOCENTER_EN: idle CLAMP channels return to CENTER by STEP_MAX per frame.
module multi_axis_input_ctrl #(
  parameter int CHANNELS   = 2,
  parameter int WIDTH      = 8,
  parameter int STEP_MIN   = 1,
  parameter int STEP_MAX   = 8,
  parameter int ACC_FRAMES = 4,
  parameter int CENTER     = 2**(WIDTH-1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      strobe,
  input  logic [2*CHANNELS-1:0]     mode,
  input  logic [CHANNELS-1:0]       plus,
  input  logic [CHANNELS-1:0]       minus,
  input  logic [8*CHANNELS-1:0]     analog_in,
  output logic [WIDTH*CHANNELS-1:0] value_out,
  output logic [CHANNELS-1:0]       moving
);

  localparam int SW = $clog2(STEP_MAX + 1) + 1;
  localparam int HW = $clog2(ACC_FRAMES + 1);
  localparam int AW = WIDTH + 2;
  localparam logic [WIDTH-1:0] CTR_V  = WIDTH'(CENTER);
  localparam logic [SW-1:0]    SMIN_V = SW'(STEP_MIN);
  localparam logic [SW-1:0]    SMAX_V = SW'(STEP_MAX);

  typedef enum logic {IDLE = 1'b0, RAMP = 1'b1} state_t;

  logic strobe_q;
  logic tick;

  // Headroom of two bits lets both underflow and overflow be seen before clamping.
  function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] v, input logic down,
                                               input logic [SW-1:0] s, input logic wrap);
    logic [AW-1:0] sum;
    sum = down ? ({2'b00, v} - AW'(s)) : ({2'b00, v} + AW'(s));
    if (wrap)
      return sum[WIDTH-1:0];
    else if (sum[AW-1])
      return '0;
    else if (sum[AW-2])
      return '1;
    else
      return sum[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] f_analog(input logic [7:0] a);
    return WIDTH'({a ^ 8'h80, 16'h0000} >> (24 - WIDTH));
  endfunction

`ifdef PADDLE_AUTOCENTER_EN
  function automatic logic [WIDTH-1:0] f_center(input logic [WIDTH-1:0] v);
    if (v > CTR_V)
      return ((v - CTR_V) > WIDTH'(STEP_MAX)) ? (v - WIDTH'(STEP_MAX)) : CTR_V;
    else if (v < CTR_V)
      return ((CTR_V - v) > WIDTH'(STEP_MAX)) ? (v + WIDTH'(STEP_MAX)) : CTR_V;
    else
      return v;
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) strobe_q <= 1'b0;
    else       strobe_q <= strobe;
  end

  assign tick = strobe & ~strobe_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t           state_q;
    logic [SW-1:0]    step_q;
    logic [HW-1:0]    hold_q;
    logic [WIDTH-1:0] value_q;
    logic [1:0]       mode_q;
    logic [1:0]       dir_q;
    logic             moving_q;
    logic [1:0]       ch_mode;
    logic [1:0]       dir;        // [1] decrease, [0] increase
    logic             is_wrap;
    logic             is_analog;
    logic [7:0]       ain;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] min_val;
    logic [SW:0]      dbl;
    logic [SW-1:0]    step_dbl;

    assign ch_mode   = mode[2*c +: 2];
    assign ain       = analog_in[8*c +: 8];
    assign dir       = {minus[c] & ~plus[c], plus[c] & ~minus[c]};
    assign is_wrap   = (ch_mode == 2'b01);
    assign is_analog = (ch_mode == 2'b10);
    assign step_val  = f_step(value_q, dir[1], step_q, is_wrap);
    assign min_val   = f_step(value_q, dir[1], SMIN_V, is_wrap);
    assign dbl       = {step_q, 1'b0};
    assign step_dbl  = (dbl > {1'b0, SMAX_V}) ? SMAX_V : dbl[SW-1:0];

    // The frame that starts a ramp counts as the first of ACC_FRAMES at STEP_MIN.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q  <= IDLE;
        step_q   <= SMIN_V;
        hold_q   <= '0;
        value_q  <= CTR_V;
        mode_q   <= 2'b00;
        dir_q    <= 2'b00;
        moving_q <= 1'b0;
      end else begin
        mode_q <= ch_mode;
        if (ch_mode != mode_q) begin
          state_q  <= IDLE;
          step_q   <= SMIN_V;
          hold_q   <= '0;
          moving_q <= 1'b0;
        end else if (is_analog) begin
          value_q  <= f_analog(ain);
          moving_q <= (ain != 8'h00);
          state_q  <= IDLE;
          step_q   <= SMIN_V;
          hold_q   <= '0;
        end else if (tick) begin
          case (state_q)
            IDLE: begin
              if (dir != 2'b00) begin
                state_q  <= RAMP;
                value_q  <= min_val;
                step_q   <= SMIN_V;
                hold_q   <= HW'(1);
                dir_q    <= dir;
                moving_q <= 1'b1;
              end else begin
                moving_q <= 1'b0;
`ifdef PADDLE_AUTOCENTER_EN
                if (!is_wrap) value_q <= f_center(value_q);
`endif
              end
            end
            RAMP: begin
              if (dir == 2'b00) begin
                state_q  <= IDLE;
                step_q   <= SMIN_V;
                hold_q   <= '0;
                moving_q <= 1'b0;
              end else if (dir != dir_q) begin
                value_q <= min_val;
                step_q  <= SMIN_V;
                hold_q  <= HW'(1);
                dir_q   <= dir;
              end else begin
                value_q <= step_val;
                if (hold_q >= HW'(ACC_FRAMES - 1)) begin
                  step_q <= step_dbl;
                  hold_q <= '0;
                end else begin
                  hold_q <= hold_q + HW'(1);
                end
              end
            end
            default: begin
              state_q  <= IDLE;
              moving_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign value_out[WIDTH*c +: WIDTH] = value_q;
    assign moving[c]                   = moving_q;
  end

endmodule

// File: tb/tb_multi_axis_input_ctrl.sv
// Directed self-checking bench for multi_axis_input_ctrl (default parameters, channel 0 exercised, channel 1 idle).
module tb_multi_axis_input_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        strobe = 1'b0;
  logic [3:0]  mode = 4'b0000;
  logic [1:0]  plus = 2'b00;
  logic [1:0]  minus = 2'b00;
  logic [15:0] analog_in = 16'h0000;
  logic [15:0] value_out;
  logic [1:0]  moving;

  int checks = 0;
  int failures = 0;

  multi_axis_input_ctrl dut (
    .clk(clk), .reset(reset), .strobe(strobe), .mode(mode), .plus(plus), .minus(minus),
    .analog_in(analog_in), .value_out(value_out), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic tick_once();
    @(negedge clk) strobe = 1'b1;
    @(negedge clk) strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; plus = 2'b00; minus = 2'b00; mode = 4'b0000; analog_in = 16'h0000; strobe = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
  endtask

  // Park channel 0 at a known value via ANALOG, then switch to the target mode.
  task automatic load_analog(input logic [7:0] a, input logic [1:0] tmode);
    @(negedge clk);
    mode[1:0] = 2'b10; analog_in[7:0] = a;
    repeat (3) @(negedge clk);
    mode[1:0] = tmode; analog_in[7:0] = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] exp_v;
    do_reset();
    checks++;
    if (value_out !== 16'h8080 || moving !== 2'b00) begin
      failures++;
      $display("FAIL reset_state: value=%h moving=%b expected 8080/00", value_out, moving);
    end
    plus[0] = 1'b1;
    repeat (10) tick_once();
    exp_v = 8'h94;
    checks++;
    if (value_out[7:0] !== exp_v || moving[0] !== 1'b1) begin
      failures++;
      $display("FAIL mid_ramp: value=%h moving=%b expected %h/1", value_out[7:0], moving[0], exp_v);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (value_out !== 16'h8080 || moving !== 2'b00) begin
      failures++;
      $display("FAIL async_reset: value=%h moving=%b expected 8080/00", value_out, moving);
    end
    plus = 2'b00;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_accel();
    logic [7:0] exp_tab [12] = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h86, 8'h88,
                                 8'h8A, 8'h8C, 8'h90, 8'h94, 8'h98, 8'h9C};
    do_reset();
    plus[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick_once();
      checks++;
      if (value_out[7:0] !== exp_tab[i] || moving[0] !== 1'b1) begin
        failures++;
        $display("FAIL accel_tick%0d: value=%h moving=%b expected %h/1", i + 1, value_out[7:0], moving[0], exp_tab[i]);
      end
    end
    plus[0] = 1'b0;
    tick_once();
    checks++;
    if (value_out[7:0] !== 8'h9C || moving[0] !== 1'b0) begin
      failures++;
      $display("FAIL accel_release: value=%h moving=%b expected 9c/0", value_out[7:0], moving[0]);
    end
    checks++;
    if (value_out[15:8] !== 8'h80 || moving[1] !== 1'b0) begin
      failures++;
      $display("FAIL ch1_independent: value=%h moving=%b expected 80/0", value_out[15:8], moving[1]);
    end
  endtask

  task automatic test_clamp_wrap();
    // Acceleration needs ACC_FRAMES frames, so all three wrap steps are 1.
    logic [7:0] wrap_tab [3] = '{8'h00, 8'hFF, 8'hFE};
    do_reset();
    load_analog(8'h7E, 2'b00);
    checks++;
    if (value_out[7:0] !== 8'hFE) begin
      failures++;
      $display("FAIL clamp_start: value=%h expected fe", value_out[7:0]);
    end
    plus[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_once();
      checks++;
      if (value_out[7:0] !== 8'hFF) begin
        failures++;
        $display("FAIL clamp_tick%0d: value=%h expected ff", i + 1, value_out[7:0]);
      end
    end
    plus[0] = 1'b0;
    do_reset();
    load_analog(8'h81, 2'b01);
    checks++;
    if (value_out[7:0] !== 8'h01) begin
      failures++;
      $display("FAIL wrap_start: value=%h expected 01", value_out[7:0]);
    end
    minus[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_once();
      checks++;
      if (value_out[7:0] !== wrap_tab[i]) begin
        failures++;
        $display("FAIL wrap_tick%0d: value=%h expected %h", i + 1, value_out[7:0], wrap_tab[i]);
      end
    end
    minus[0] = 1'b0;
  endtask

  task automatic test_simul_reverse();
    do_reset();
    plus[0] = 1'b1; minus[0] = 1'b1;
    repeat (5) tick_once();
    checks++;
    if (value_out[7:0] !== 8'h80 || moving[0] !== 1'b0) begin
      failures++;
      $display("FAIL both_pressed: value=%h moving=%b expected 80/0", value_out[7:0], moving[0]);
    end
    minus[0] = 1'b0;
    repeat (5) tick_once();
    checks++;
    if (value_out[7:0] !== 8'h86) begin
      failures++;
      $display("FAIL pre_reverse: value=%h expected 86", value_out[7:0]);
    end
    plus[0] = 1'b0; minus[0] = 1'b1;
    tick_once();
    checks++;
    if (value_out[7:0] !== 8'h85 || moving[0] !== 1'b1) begin
      failures++;
      $display("FAIL reverse_first: value=%h moving=%b expected 85/1", value_out[7:0], moving[0]);
    end
    tick_once();
    checks++;
    if (value_out[7:0] !== 8'h84) begin
      failures++;
      $display("FAIL reverse_second: value=%h expected 84", value_out[7:0]);
    end
    minus[0] = 1'b0;
  endtask

  task automatic test_analog();
    do_reset();
    @(negedge clk) mode[1:0] = 2'b10;
    repeat (2) @(negedge clk);
    analog_in[7:0] = 8'hC0;
    #1;
    checks++;
    if (value_out[7:0] !== 8'h80) begin
      failures++;
      $display("FAIL analog_latency: value=%h expected 80 before edge", value_out[7:0]);
    end
    @(negedge clk);
    checks++;
    if (value_out[7:0] !== 8'h40 || moving[0] !== 1'b1) begin
      failures++;
      $display("FAIL analog_value: value=%h moving=%b expected 40/1", value_out[7:0], moving[0]);
    end
    mode[1:0] = 2'b00; strobe = 1'b1; plus[0] = 1'b1;
    @(negedge clk);
    checks++;
    if (value_out[7:0] !== 8'h40 || moving[0] !== 1'b0) begin
      failures++;
      $display("FAIL analog_switch: value=%h moving=%b expected 40/0", value_out[7:0], moving[0]);
    end
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (value_out[7:0] !== 8'h40 || moving[0] !== 1'b0) begin
      failures++;
      $display("FAIL tick_dropped: value=%h moving=%b expected 40/0", value_out[7:0], moving[0]);
    end
    plus[0] = 1'b0; analog_in[7:0] = 8'h00;
  endtask

  task automatic test_autocenter();
`ifdef PADDLE_AUTOCENTER_EN
    logic [7:0] ac_tab [5] = '{8'h98, 8'h90, 8'h88, 8'h80, 8'h80};
`else
    logic [7:0] ac_tab [5] = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0};
`endif
    do_reset();
    load_analog(8'h20, 2'b00);
    checks++;
    if (value_out[7:0] !== 8'hA0) begin
      failures++;
      $display("FAIL autocenter_start: value=%h expected a0", value_out[7:0]);
    end
    for (int i = 0; i < 5; i++) begin
      tick_once();
      checks++;
      if (value_out[7:0] !== ac_tab[i]) begin
        failures++;
        $display("FAIL autocenter_tick%0d: value=%h expected %h", i + 1, value_out[7:0], ac_tab[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_accel();
    test_clamp_wrap();
    test_simul_reverse();
    test_analog();
    test_autocenter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
